// File: rtl/fma_scheduler.sv
// fma_scheduler: round-robin sharing of one FMA unit between NREQ requesters,
// with per-channel operand handshake, answer capture and a watchdog abort.
module fma_scheduler #(
    parameter int FP      = 32,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid_in,
    output logic [NREQ-1:0]      req_ready_out,
    input  logic [NREQ*FP-1:0]   req_a_in,
    input  logic [NREQ*FP-1:0]   req_b_in,
    output logic [NREQ-1:0]      resp_valid_out,
    output logic [FP-1:0]        resp_data_out,
    output logic                 resp_ovf_out,
    output logic                 resp_unf_out,
    output logic                 resp_err_out,
    output logic                 fma_0_req_out,
    output logic                 fma_1_req_out,
    output logic [FP-1:0]        fma_0_data_out,
    output logic [FP-1:0]        fma_1_data_out,
    input  logic                 fma_0_busy_in,
    input  logic                 fma_1_busy_in,
    input  logic                 fma_busy_in,
    input  logic                 fma_ready_in,
    input  logic [FP-1:0]        fma_result_in,
    input  logic                 fma_ovf_in,
    input  logic                 fma_unf_in,
    output logic                 busy_out,
    output logic [2:0]           state_out
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT    = 3'd2,
        S_RESPOND = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   next_ptr;
    logic            found;
    logic            grant;
    logic [FP-1:0]   sel_a;
    logic [FP-1:0]   sel_b;
    logic [FP-1:0]   a_q;
    logic [FP-1:0]   b_q;
    logic            pend_0;
    logic            pend_1;
    logic            pend_0_nxt;
    logic            pend_1_nxt;
    logic [CW-1:0]   cnt;
    logic            timed_out;
    logic [NREQ-1:0] gnt_onehot;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = PW'((32'(ptr) + i) % NREQ);
            if (!found && req_valid_in[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel == PW'(i)) begin
                sel_a = req_a_in[i*FP +: FP];
                sel_b = req_b_in[i*FP +: FP];
            end
        end
    end

    assign grant         = !rst && (state == S_IDLE) && !fma_busy_in && found;
    assign req_ready_out = grant ? (NREQ'(1) << sel) : '0;
    assign gnt_onehot    = NREQ'(1) << gnt;
    assign next_ptr      = (gnt == PW'(NREQ - 1)) ? '0 : gnt + PW'(1);

    assign pend_0_nxt = pend_0 & fma_0_busy_in;
    assign pend_1_nxt = pend_1 & fma_1_busy_in;
    // >= rather than ==: a final acceptance on the last LOAD cycle leaves the counter
    // past TIMEOUT-1 in WAIT, and the watchdog must still fire there.
    assign timed_out  = cnt >= CW'(TIMEOUT - 1);

    assign fma_0_req_out  = pend_0;
    assign fma_1_req_out  = pend_1;
    assign fma_0_data_out = (state == S_LOAD) ? a_q : '0;
    assign fma_1_data_out = (state == S_LOAD) ? b_q : '0;
    assign busy_out       = (state != S_IDLE);
    assign state_out      = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            ptr            <= '0;
            gnt            <= '0;
            a_q            <= '0;
            b_q            <= '0;
            pend_0         <= 1'b0;
            pend_1         <= 1'b0;
            cnt            <= '0;
            resp_valid_out <= '0;
            resp_data_out  <= '0;
            resp_ovf_out   <= 1'b0;
            resp_unf_out   <= 1'b0;
            resp_err_out   <= 1'b0;
        end else begin
            resp_valid_out <= '0;
            resp_data_out  <= '0;
            resp_ovf_out   <= 1'b0;
            resp_unf_out   <= 1'b0;
            resp_err_out   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        gnt    <= sel;
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        cnt    <= '0;
                        pend_0 <= 1'b1;
                        pend_1 <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt    <= cnt + 1'b1;
                    pend_0 <= pend_0_nxt;
                    pend_1 <= pend_1_nxt;
                    if (!pend_0_nxt && !pend_1_nxt) begin
                        state <= S_WAIT;
                    end else if (timed_out) begin
                        state          <= S_ERROR;
                        pend_0         <= 1'b0;
                        pend_1         <= 1'b0;
                        resp_valid_out <= gnt_onehot;
                        resp_err_out   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (fma_ready_in) begin
                        state          <= S_RESPOND;
                        resp_valid_out <= gnt_onehot;
                        resp_data_out  <= fma_result_in;
                        resp_ovf_out   <= fma_ovf_in;
                        resp_unf_out   <= fma_unf_in;
                    end else if (timed_out) begin
                        state          <= S_ERROR;
                        resp_valid_out <= gnt_onehot;
                        resp_err_out   <= 1'b1;
                    end
                end
                S_RESPOND, S_ERROR: begin
                    ptr   <= next_ptr;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fma_scheduler.sv
// tb_fma_scheduler: requesters and a behavioural FMA around fma_scheduler,
// with expected grants, timing and responses derived from round-robin arithmetic.
module tb_fma_scheduler;
    localparam int FP      = 32;
    localparam int NREQ    = 3;
    localparam int TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid_in;
    logic [NREQ-1:0]    req_ready_out;
    logic [NREQ*FP-1:0] req_a_in;
    logic [NREQ*FP-1:0] req_b_in;
    logic [NREQ-1:0]    resp_valid_out;
    logic [FP-1:0]      resp_data_out;
    logic               resp_ovf_out;
    logic               resp_unf_out;
    logic               resp_err_out;
    logic               fma_0_req_out;
    logic               fma_1_req_out;
    logic [FP-1:0]      fma_0_data_out;
    logic [FP-1:0]      fma_1_data_out;
    logic               fma_0_busy_in;
    logic               fma_1_busy_in;
    logic               fma_busy_in;
    logic               fma_ready_in;
    logic [FP-1:0]      fma_result_in;
    logic               fma_ovf_in;
    logic               fma_unf_in;
    logic               busy_out;
    logic [2:0]         state_out;

    fma_scheduler #(.FP(FP), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_a_in(req_a_in), .req_b_in(req_b_in),
        .resp_valid_out(resp_valid_out), .resp_data_out(resp_data_out),
        .resp_ovf_out(resp_ovf_out), .resp_unf_out(resp_unf_out), .resp_err_out(resp_err_out),
        .fma_0_req_out(fma_0_req_out), .fma_1_req_out(fma_1_req_out),
        .fma_0_data_out(fma_0_data_out), .fma_1_data_out(fma_1_data_out),
        .fma_0_busy_in(fma_0_busy_in), .fma_1_busy_in(fma_1_busy_in),
        .fma_busy_in(fma_busy_in), .fma_ready_in(fma_ready_in),
        .fma_result_in(fma_result_in), .fma_ovf_in(fma_ovf_in), .fma_unf_in(fma_unf_in),
        .busy_out(busy_out), .state_out(state_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ptr = 0;
    logic [FP-1:0] ra [NREQ];
    logic [FP-1:0] rb [NREQ];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_out();
        return {req_ready_out, resp_valid_out, resp_data_out, resp_ovf_out, resp_unf_out,
                resp_err_out, fma_0_req_out, fma_1_req_out, fma_0_data_out, fma_1_data_out,
                busy_out, state_out};
    endfunction

    function automatic bit bit_of(input logic [NREQ-1:0] v, input int k);
        return ((v >> k) & NREQ'(1)) != '0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a_in[i*FP +: FP] = ra[i];
            req_b_in[i*FP +: FP] = rb[i];
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        chk("rst_pulse_outputs", all_out(), 0);
        req_valid_in = '0;
        #2;
        rst = 1'b0;
        ptr = 0;
        step();
    endtask

    // One transaction; b0/b1 = busy cycles per channel, rd = WAIT cycles before the answer,
    // abort_c >= 0 pulses reset on that cycle after LOAD entry.
    task automatic run_op(input logic [NREQ-1:0] mask, input int idle_busy, input int b0,
                          input int b1, input int rd, input logic [FP-1:0] res,
                          input logic ovf, input logic unf, input int abort_c);
        int g;
        int load_len;
        int ready_c;
        int end_c;
        bit err_exp;
        bit in_load;
        logic [FP-1:0] a_exp;
        logic [FP-1:0] b_exp;
        logic [NREQ-1:0] g_oh;
        g = -1;
        for (int i = 0; i < NREQ; i++)
            if (g < 0 && bit_of(mask, (ptr + i) % NREQ)) g = (ptr + i) % NREQ;
        g_oh  = NREQ'(1) << g;
        a_exp = ra[g];
        b_exp = rb[g];
        req_valid_in = mask;
        drive_ops();
        fma_busy_in = 1'b1;
        for (int k = 0; k < idle_busy; k++) begin
            fma_ready_in = 1'($urandom);
            #1;
            chk("idle_busy_ready", req_ready_out, 0);
            chk("idle_busy_state", state_out, 0);
            step();
        end
        fma_busy_in  = 1'b0;
        fma_ready_in = 1'($urandom);
        #1;
        chk("grant", req_ready_out, g_oh);
        chk("idle_state", {busy_out, state_out}, 0);
        chk("idle_resp", {resp_valid_out, resp_data_out, resp_ovf_out, resp_unf_out, resp_err_out}, 0);
        chk("idle_fma_req", {fma_0_req_out, fma_1_req_out}, 0);
        step();
        req_valid_in = mask & ~g_oh;
        ra[g] = $urandom;
        rb[g] = $urandom;
        drive_ops();
        load_len = ((b0 > b1) ? b0 : b1) + 1;
        ready_c  = load_len + rd;
        err_exp  = (load_len > TIMEOUT) ||
                   (ready_c > TIMEOUT - 1 && !(rd == 0 && load_len == TIMEOUT));
        end_c    = err_exp ? TIMEOUT : ready_c + 1;
        for (int c = 0; c < end_c; c++) begin
            in_load = (c < load_len);
            fma_0_busy_in = (c < b0) ? 1'b1 : (c == b0) ? 1'b0 : 1'($urandom);
            fma_1_busy_in = (c < b1) ? 1'b1 : (c == b1) ? 1'b0 : 1'($urandom);
            fma_busy_in   = 1'($urandom);
            fma_ready_in  = in_load ? 1'($urandom) : (c == ready_c);
            fma_result_in = (c == ready_c) ? res : $urandom;
            fma_ovf_in    = (c == ready_c) ? ovf : 1'($urandom);
            fma_unf_in    = (c == ready_c) ? unf : 1'($urandom);
            if (c == abort_c) begin
                #1;
                rst = 1'b1;
                #1;
                chk("rst_mid_outputs", all_out(), 0);
                req_valid_in = '0;
                fma_ready_in = 1'b0;
                #2;
                rst = 1'b0;
                ptr = 0;
                step();
                return;
            end
            #1;
            chk("op_state", {busy_out, state_out}, in_load ? 4'b1001 : 4'b1010);
            chk("op_fma_req", {fma_0_req_out, fma_1_req_out},
                {in_load && c <= b0, in_load && c <= b1});
            chk("op_fma_data", {fma_0_data_out, fma_1_data_out}, in_load ? {a_exp, b_exp} : 64'd0);
            chk("op_resp_idle", {resp_valid_out, resp_data_out, resp_ovf_out, resp_unf_out, resp_err_out}, 0);
            chk("op_no_grant", req_ready_out, 0);
            step();
        end
        fma_ready_in  = 1'($urandom);
        fma_result_in = $urandom;
        #1;
        chk("end_state", state_out, err_exp ? 4 : 3);
        chk("resp_valid", resp_valid_out, g_oh);
        chk("resp_data", resp_data_out, err_exp ? 32'd0 : res);
        chk("resp_flags", {resp_ovf_out, resp_unf_out, resp_err_out}, err_exp ? 3'b001 : {ovf, unf, 1'b0});
        chk("end_fma_idle", {fma_0_req_out, fma_1_req_out, fma_0_data_out, fma_1_data_out}, 0);
        chk("end_no_grant", req_ready_out, 0);
        ptr = (g + 1) % NREQ;
        fma_ready_in = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        req_valid_in = '0;
        req_a_in = '0;
        req_b_in = '0;
        fma_0_busy_in = 1'b0;
        fma_1_busy_in = 1'b0;
        fma_busy_in = 1'b0;
        fma_ready_in = 1'b0;
        fma_result_in = '0;
        fma_ovf_in = 1'b0;
        fma_unf_in = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
        end
        drive_ops();
        #12;
        chk("reset_outputs", all_out(), 0);
        rst = 1'b0;
        step();

        ra[0] = 32'h4000_0000;
        rb[0] = 32'h4040_0000;
        run_op(3'b001, 0, 0, 0, 3, 32'h40C0_0000, 1'b0, 1'b0, -1);
        run_op(3'b011, 0, 0, 0, 1, $urandom, 1'b0, 1'b0, -1);
        reset_pulse();
        for (int n = 0; n < 4; n++) run_op(3'b011, 0, 0, 0, n, $urandom, 1'b0, 1'b0, -1);
        run_op(3'b001, 0, 0, 5, 2, $urandom, 1'b0, 1'b0, -1);
        run_op(3'b100, 0, 3, 1, 0, 32'h7F80_0000, 1'b1, 1'b0, -1);
        run_op(3'b010, 0, 0, 0, 2, 32'h0000_0001, 1'b0, 1'b1, -1);
        run_op(3'b111, 3, 1, 0, 1, $urandom, 1'b1, 1'b1, -1);
        run_op(3'b101, 0, 0, 0, 40, $urandom, 1'b0, 1'b0, -1);
        run_op(3'b101, 0, 0, 0, 0, $urandom, 1'b0, 1'b0, -1);
        run_op(3'b011, 0, 2, TIMEOUT + 3, 0, $urandom, 1'b0, 1'b0, -1);
        run_op(3'b110, 0, TIMEOUT - 1, 0, 0, $urandom, 1'b1, 1'b0, -1);
        run_op(3'b001, 0, 0, 0, TIMEOUT - 2, $urandom, 1'b0, 1'b1, -1);
        run_op(3'b001, 0, 0, 0, TIMEOUT - 1, $urandom, 1'b0, 1'b0, -1);
        run_op(3'b010, 0, 0, 0, 1, $urandom, 1'b0, 1'b0, -1);
        run_op(3'b100, 0, 0, 0, 10, $urandom, 1'b0, 1'b0, 3);
        run_op(3'b111, 0, 0, 0, 1, $urandom, 1'b0, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            run_op(NREQ'($urandom_range(1, 7)), $urandom_range(0, 2), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 6), $urandom,
                   1'($urandom), 1'($urandom), -1);
        end

        req_valid_in = '0;
        #1;
        chk("final_idle", {busy_out, state_out, resp_valid_out, resp_err_out}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fma_scheduler.md
# fma_scheduler

Round-robin scheduler that shares one floating-point FMA unit between NREQ requesters. Each accepted request is captured, its two operands are driven into the FMA's float_0/float_1 request/busy channels, and the scheduler waits for the FMA's answer-ready pulse. It then returns the result and the overflow/underflow flags to the granted requester. A watchdog aborts stalled operations with an error response. The block sits between the requester fabric and the FMA's input/handshake ports.

## Interface
- FP, 32, operand/result width (IEEE-754 single bit pattern)
- NREQ, 2, number of requesters (2..4)
- TIMEOUT, 64, cycles allowed from LOAD entry to FMA answer before abort (≥4)
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid_in  in  NREQ  requester i has an operation pending
- req_ready_out  out  NREQ  grant/accept strobe for requester i
- req_a_in  in  NREQ*FP  operand A of requester i, slice [i*FP +: FP]
- req_b_in  in  NREQ*FP  operand B of requester i
- resp_valid_out  out  NREQ  one-cycle response strobe to requester i
- resp_data_out  out  FP  result, shared bus, qualified by resp_valid_out
- resp_ovf_out / resp_unf_out / resp_err_out  out  1 each  overflow, underflow, timeout flags
- fma_0_req_out, fma_1_req_out  out  1 each  operand channel request
- fma_0_data_out, fma_1_data_out  out  FP each  operand data, stable while request high
- fma_0_busy_in, fma_1_busy_in  in  1 each  FMA channel busy (cannot accept)
- fma_busy_in  in  1  FMA unit busy overall
- fma_ready_in  in  1  answer-ready strobe from FMA
- fma_result_in  in  FP  FMA answer
- fma_ovf_in, fma_unf_in  in  1 each  FMA overflow/underflow
- busy_out  out  1  high whenever state ≠ IDLE
- state_out  out  3  encoded state: IDLE=0, LOAD=1, WAIT=2, RESPOND=3, ERROR=4

## Operation
- Reset: state IDLE, rr pointer 0, all outputs 0, counter 0, operand/result regs 0.
- IDLE: if any req_valid_in and fma_busy_in=0, grant g = first i with req_valid_in[i] scanning ptr, ptr+1, … mod NREQ.
  - req_ready_out[g]=1 combinationally in that cycle only. Capture A/B and g, clear counter, go to LOAD.
  - If fma_busy_in=1, no grant is issued and req_ready_out stays 0.
- LOAD: each channel has an independent pending bit, set on LOAD entry.
  - fma_k_req_out = pending_k. A transfer completes on a cycle with req=1 and fma_k_busy_in=0; pending_k clears next edge.
  - fma_0_data_out=A, fma_1_data_out=B, held for the whole of LOAD.
  - When both pending bits are clear, go to WAIT.
- WAIT: on fma_ready_in=1, latch result and flags and go to RESPOND. fma_ready_in is ignored in every other state.
- RESPOND (1 cycle): resp_valid_out[g]=1 with latched data/ovf/unf, err=0. ptr←(g+1) mod NREQ. Go to IDLE.
- Timeout: counter increments every cycle in LOAD/WAIT. When counter = TIMEOUT-1 and the exit condition is not met, go to ERROR.
- ERROR (1 cycle): fma_*_req_out=0, resp_valid_out[g]=1, resp_err_out=1, data/ovf/unf=0, ptr←(g+1) mod NREQ. Go to IDLE.
- resp_* data/flag outputs are 0 whenever no resp_valid_out bit is set.
- Requesters must hold valid and operands until ready; the scheduler never drops an unaccepted request.

## Timing
- Best case: grant at cycle T. LOAD at T+1 with both channels accepted at T+1. WAIT at T+2. fma_ready_in at T+k gives resp_valid at T+k+1. Next grant is possible at T+k+2.
- Channels may complete on different cycles. WAIT entry is the cycle after the later completion.
- Simultaneous fma_ready_in and timeout in WAIT: ready wins, normal response.
- Simultaneous final channel acceptance and timeout in LOAD: acceptance wins, go to WAIT. The counter is not cleared.
- rst asserted mid-operation: immediate return to reset values. No response is issued for the in-flight request.
- Pointer wrap: g=NREQ-1 sets ptr to 0.

## Test plan
- Single request: req 0 with A=0x40000000, B=0x40400000, busy lines low, fma_ready_in 3 cycles after WAIT with result 0x40C00000 -> req_ready_out[0] at T, fma_*_req_out at T+1, resp_valid_out[0] with 0x40C00000 and flags 0.
- Fairness: both requesters valid continuously for 4 operations -> grants ordered 0,1,0,1. With ptr=1 after reset+one op, req 1 is granted first.
- Staggered channel busy: fma_1_busy_in high 5 cycles into LOAD -> fma_0_req_out drops after 1 cycle, fma_1_req_out stays high 6 cycles, data stable throughout, WAIT entered the cycle after channel 1 accepts.
- Flags: fma_ready_in with fma_ovf_in=1, result 0x7F800000 -> resp_ovf_out=1, resp_unf_out=0 for exactly one cycle.
- Timeout: TIMEOUT=8, fma_ready_in never asserted -> ERROR at 8 cycles after LOAD entry, resp_valid_out[g]=1 with resp_err_out=1 and data 0, then IDLE and the next request is granted.
- Reset mid-WAIT: rst pulse -> all outputs 0 asynchronously, state_out=0, no resp_valid_out, and a subsequent request is granted to requester 0.
